// File: rtl/hms_clock_core.sv
// hms_clock_core: hour:minute:second timekeeping core with debounced push-button setup mode.
// Single clock domain; the seconds tick and the setup blink come from clock-enable counters.

module hms_clock_core #(
  parameter int TICK_DIV   = 50000000,
  parameter int DEB_CYCLES = 500000,
  parameter int HOUR_MAX   = 23
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sw0,
  input  logic       i_sw1,
  input  logic       i_sw2,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic       o_mode,
  output logic [1:0] o_position,
  output logic       o_blink,
  output logic       o_tick,
  output logic       o_day_hit
);

  localparam int PW        = $clog2(TICK_DIV);
  localparam int DW        = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int BLINK_DIV = TICK_DIV / 4;
  localparam int BW        = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [4:0]    HOUR_LAST  = 5'(HOUR_MAX);
  localparam logic [5:0]    MS_LAST    = 6'd59;

  typedef enum logic {S_CLOCK = 1'b0, S_SETUP = 1'b1} mode_t;
  typedef enum logic [1:0] {POS_SEC = 2'd0, POS_MIN = 2'd1, POS_HOUR = 2'd2} pos_t;

  logic [2:0]    w_btn;
  logic [2:0]    r_sync1, r_sync2, r_smp, r_deb, r_press;
  logic [2:0]    w_fall, w_rise;
  logic [DW-1:0] r_deb_cnt;
  logic          w_deb_stb;
  logic          w_p0, w_p1, w_p2;

  mode_t         r_state, w_state_nxt;
  logic          w_setup, w_edit, w_enter;
  pos_t          r_pos;

  logic [PW-1:0] r_presc, w_presc_nxt;
  logic          r_tick, r_day_hit, w_at_max;
  logic [5:0]    r_sec, r_min;
  logic [4:0]    r_hour;
  logic [BW-1:0] r_blink_cnt;
  logic          r_blink;

  assign w_btn = {i_sw2, i_sw1, i_sw0};

  // NOTE: synchroniser and debounce state reset to '1 (released), not 0, so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
    end
  end

  assign w_deb_stb = (r_deb_cnt == DEB_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_deb_cnt <= '0;
    end else if (w_deb_stb) begin
      r_deb_cnt <= '0;
    end else begin
      r_deb_cnt <= r_deb_cnt + 1'b1;
    end
  end

  // A press needs two low samples while released; release needs two high samples.
  assign w_fall = ~r_sync2 & ~r_smp & r_deb;
  assign w_rise =  r_sync2 &  r_smp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_smp   <= '1;
      r_deb   <= '1;
      r_press <= '0;
    end else if (w_deb_stb) begin
      r_smp   <= r_sync2;
      r_deb   <= (r_deb & ~w_fall) | w_rise;
      r_press <= w_fall;
    end else begin
      r_press <= '0;
    end
  end

  assign w_p0 = r_press[0];
  assign w_p1 = r_press[1];
  assign w_p2 = r_press[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_CLOCK;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    if (w_p0) w_state_nxt = (r_state == S_CLOCK) ? S_SETUP : S_CLOCK;
  end

  // Mode change always beats p1/p2 arriving in the same cycle.
  always_comb begin
    w_setup = (r_state == S_SETUP);
    w_edit  = w_setup && !w_p0;
    w_enter = !w_setup && w_p0;
    o_mode  = w_setup;
  end

  always_comb begin
    w_presc_nxt = r_presc + 1'b1;
    if (w_setup || w_enter || (r_presc == PRESC_LAST)) w_presc_nxt = '0;
  end

  // Time is frozen in the cycle before a tick, so the current value decides the rollover flag.
  assign w_at_max = (r_sec == MS_LAST) && (r_min == MS_LAST) && (r_hour == HOUR_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc   <= '0;
      r_tick    <= 1'b0;
      r_day_hit <= 1'b0;
    end else begin
      r_presc   <= w_presc_nxt;
      r_tick    <= (w_presc_nxt == PRESC_LAST);
      r_day_hit <= (w_presc_nxt == PRESC_LAST) && w_at_max;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sec  <= '0;
      r_min  <= '0;
      r_hour <= '0;
    end else if (r_tick) begin
      if (r_sec == MS_LAST) begin
        r_sec <= '0;
        if (r_min == MS_LAST) begin
          r_min  <= '0;
          r_hour <= (r_hour == HOUR_LAST) ? 5'd0 : r_hour + 5'd1;
        end else begin
          r_min <= r_min + 6'd1;
        end
      end else begin
        r_sec <= r_sec + 6'd1;
      end
    end else if (w_edit && w_p2) begin
      case (r_pos)
        POS_SEC:  r_sec  <= (r_sec  == MS_LAST)   ? 6'd0 : r_sec  + 6'd1;
        POS_MIN:  r_min  <= (r_min  == MS_LAST)   ? 6'd0 : r_min  + 6'd1;
        POS_HOUR: r_hour <= (r_hour == HOUR_LAST) ? 5'd0 : r_hour + 5'd1;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos <= POS_SEC;
    end else if (w_enter) begin
      r_pos <= POS_SEC;
    end else if (w_edit && w_p1) begin
      case (r_pos)
        POS_SEC: r_pos <= POS_MIN;
        POS_MIN: r_pos <= POS_HOUR;
        default: r_pos <= POS_SEC;
      endcase
    end
  end

  // Blink is solid outside SETUP and restarts high on every SETUP entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
    end else if (!w_edit) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b1;
    end else if (r_blink_cnt == BLINK_LAST) begin
      r_blink_cnt <= '0;
      r_blink     <= ~r_blink;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  assign o_sec      = r_sec;
  assign o_min      = r_min;
  assign o_hour     = r_hour;
  assign o_position = r_pos;
  assign o_blink    = r_blink;
  assign o_tick     = r_tick;
  assign o_day_hit  = r_day_hit;

endmodule

// File: tb/tb_hms_clock_core.sv
// tb_hms_clock_core: directed bench for hms_clock_core with TICK_DIV=8, DEB_CYCLES=2, HOUR_MAX=23.
// Inputs change and outputs are sampled on the falling clock edge.

module tb_hms_clock_core;

  localparam int TICK_DIV   = 8;
  localparam int DEB_CYCLES = 2;
  localparam int HOUR_MAX   = 23;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw0 = 1'b1, sw1 = 1'b1, sw2 = 1'b1;
  logic [5:0] o_sec, o_min;
  logic [4:0] o_hour;
  logic       o_mode, o_blink, o_tick, o_day_hit;
  logic [1:0] o_position;

  int checks = 0;
  int failures = 0;

  hms_clock_core #(
    .TICK_DIV  (TICK_DIV),
    .DEB_CYCLES(DEB_CYCLES),
    .HOUR_MAX  (HOUR_MAX)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_sw0     (sw0),
    .i_sw1     (sw1),
    .i_sw2     (sw2),
    .o_sec     (o_sec),
    .o_min     (o_min),
    .o_hour    (o_hour),
    .o_mode    (o_mode),
    .o_position(o_position),
    .o_blink   (o_blink),
    .o_tick    (o_tick),
    .o_day_hit (o_day_hit)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0:       sw0 = v;
      1:       sw1 = v;
      default: sw2 = v;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b0);
    cyc(10);
    set_btn(b, 1'b1);
    cyc(10);
  endtask

  task automatic wait_mode(input logic want, input string name);
    int n = 0;
    while (o_mode !== want && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (o_mode !== want) begin
      failures++;
      $display("FAIL %s: o_mode got %b want %b after %0d cycles", name, o_mode, want, n);
    end
  endtask

  task automatic test_reset();
    cyc(3);
    checks++;
    if ({o_sec, o_min, o_hour, o_mode, o_position, o_blink, o_tick, o_day_hit} !== 23'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h want 0",
               {o_sec, o_min, o_hour, o_mode, o_position, o_blink, o_tick, o_day_hit});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_count();
    for (int k = 1; k <= 8 * 60; k++) begin
      logic exp_tick;
      int   exp_sec, exp_min;
      @(negedge clk);
      exp_tick = ((k % 8) == 7);
      exp_sec  = (k / 8) % 60;
      exp_min  = k / 480;
      checks++;
      if (o_tick !== exp_tick) begin
        failures++;
        $display("FAIL count_tick cycle %0d: got %b want %b", k, o_tick, exp_tick);
      end
      checks++;
      if (o_sec !== 6'(exp_sec) || o_min !== 6'(exp_min)) begin
        failures++;
        $display("FAIL count_time cycle %0d: got %0d:%0d want %0d:%0d", k, o_min, o_sec, exp_min, exp_sec);
      end
      checks++;
      if (o_day_hit !== 1'b0 || o_blink !== 1'b1) begin
        failures++;
        $display("FAIL count_flags cycle %0d: day_hit %b blink %b want 0 1", k, o_day_hit, o_blink);
      end
    end
  endtask

  task automatic test_blink();
    logic [5:0] pat = 6'b110011;
    sw0 = 1'b0;
    wait_mode(1'b1, "blink_enter");
    checks++;
    if (o_position !== 2'd0) begin
      failures++;
      $display("FAIL blink_entry_pos: got %0d want 0", o_position);
    end
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (o_blink !== pat[5-i]) begin
        failures++;
        $display("FAIL blink_pattern step %0d: got %b want %b", i, o_blink, pat[5-i]);
      end
    end
    sw0 = 1'b1;
    cyc(10);
  endtask

  task automatic test_day_rollover();
    int s0 = int'(o_sec), m0 = int'(o_min), h0 = int'(o_hour);
    repeat ((59 - s0 + 60) % 60) press(2);
    press(1);
    repeat ((59 - m0 + 60) % 60) press(2);
    press(1);
    repeat ((23 - h0 + 24) % 24) press(2);
    checks++;
    if ({o_hour, o_min, o_sec} !== {5'd23, 6'd59, 6'd59}) begin
      failures++;
      $display("FAIL preload_235959: got %0d:%0d:%0d want 23:59:59", o_hour, o_min, o_sec);
    end
    sw0 = 1'b0;
    wait_mode(1'b0, "rollover_exit");
    sw0 = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) @(negedge clk);
      checks++;
      if (o_tick !== (k == 8) || o_day_hit !== (k == 8)) begin
        failures++;
        $display("FAIL rollover_pulse cycle %0d: tick %b day_hit %b want %b", k, o_tick, o_day_hit, k == 8);
      end
      if (k == 9) begin
        checks++;
        if ({o_hour, o_min, o_sec} !== 17'd0) begin
          failures++;
          $display("FAIL rollover_time: got %0d:%0d:%0d want 0:0:0", o_hour, o_min, o_sec);
        end
      end
    end
  endtask

  task automatic test_setup_fields();
    int s0, m0, h0;
    press(0);
    checks++;
    if (o_mode !== 1'b1 || o_position !== 2'd0) begin
      failures++;
      $display("FAIL setup_entry: mode %b pos %0d want 1 0", o_mode, o_position);
    end
    s0 = int'(o_sec);
    m0 = int'(o_min);
    h0 = int'(o_hour);
    press(1);
    checks++;
    if (o_position !== 2'd1) begin failures++; $display("FAIL pos_step1: got %0d want 1", o_position); end
    press(1);
    checks++;
    if (o_position !== 2'd2) begin failures++; $display("FAIL pos_step2: got %0d want 2", o_position); end
    press(1);
    checks++;
    if (o_position !== 2'd0) begin failures++; $display("FAIL pos_step3: got %0d want 0", o_position); end
    press(1);
    press(1);
    repeat (25) press(2);
    checks++;
    if (o_hour !== 5'((h0 + 25) % 24) || o_min !== 6'(m0) || o_sec !== 6'(s0)) begin
      failures++;
      $display("FAIL hour_wrap: got %0d:%0d:%0d want %0d:%0d:%0d",
               o_hour, o_min, o_sec, (h0 + 25) % 24, m0, s0);
    end
  endtask

  task automatic test_bounce();
    int h0 = int'(o_hour);
    for (int i = 0; i < 10; i++) begin
      sw2 = (i % 2 == 0) ? 1'b0 : 1'b1;
      cyc(2);
    end
    sw2 = 1'b0;
    cyc(20);
    sw2 = 1'b1;
    cyc(10);
    checks++;
    if (o_hour !== 5'((h0 + 1) % 24)) begin
      failures++;
      $display("FAIL bounce_single_inc: got %0d want %0d", o_hour, (h0 + 1) % 24);
    end
  endtask

  task automatic test_p0_wins();
    int s0 = int'(o_sec), m0 = int'(o_min), h0 = int'(o_hour);
    sw0 = 1'b0;
    sw2 = 1'b0;
    wait_mode(1'b0, "p0_wins_exit");
    checks++;
    if (o_hour !== 5'(h0) || o_min !== 6'(m0) || o_sec !== 6'(s0)) begin
      failures++;
      $display("FAIL p0_wins_field: got %0d:%0d:%0d want %0d:%0d:%0d", o_hour, o_min, o_sec, h0, m0, s0);
    end
    sw0 = 1'b1;
    sw2 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge clk);
      checks++;
      if (o_tick !== (k == 8)) begin
        failures++;
        $display("FAIL exit_first_tick cycle %0d: got %b want %b", k, o_tick, k == 8);
      end
    end
    cyc(10);
  endtask

  task automatic test_async_reset();
    int s0, m0, h0;
    press(0);
    s0 = int'(o_sec);
    m0 = int'(o_min);
    h0 = int'(o_hour);
    repeat ((56 - s0 + 60) % 60) press(2);
    press(1);
    repeat ((34 - m0 + 60) % 60) press(2);
    press(1);
    repeat ((12 - h0 + 24) % 24) press(2);
    checks++;
    if ({o_mode, o_hour, o_min, o_sec} !== {1'b1, 5'd12, 6'd34, 6'd56}) begin
      failures++;
      $display("FAIL preload_123456: mode %b time %0d:%0d:%0d want 1 12:34:56", o_mode, o_hour, o_min, o_sec);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({o_sec, o_min, o_hour, o_mode, o_position, o_blink, o_tick, o_day_hit} !== 23'd0) begin
      failures++;
      $display("FAIL async_reset_immediate: got %h want 0",
               {o_sec, o_min, o_hour, o_mode, o_position, o_blink, o_tick, o_day_hit});
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc(2);
    checks++;
    if (o_mode !== 1'b0 || o_blink !== 1'b1 || {o_hour, o_min, o_sec} !== 17'd0) begin
      failures++;
      $display("FAIL after_reset_run: mode %b blink %b time %0d:%0d:%0d want 0 1 0:0:0",
               o_mode, o_blink, o_hour, o_min, o_sec);
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_blink();
    test_day_rollover();
    test_setup_fields();
    test_bounce();
    test_p0_wins();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
